keypad_event_buffer: RTL and testbench
======================================

# keypad_event_buffer

Debounces and buffers decoded keypresses from the hex keypad scanner. Consumes the scanner's 4-bit `code` and `valid` strobe, accepts a keypress only after it has been seen consistently, and emits exactly one event per press. Accepted events go into a small FIFO, which is drained by a downstream consumer over a valid/ready handshake.

## Interface
- `MATCH_COUNT`, 4: matching valid strobes needed to accept a press; legal range 2..15.
- `GAP_CYCLES`, 64: cycles without any valid strobe that count as key release; legal range 2..255.
- `DEPTH`, 8: FIFO depth; power of two, at least 2.
- `clk` in 1: single clock; every flop updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `code` in 4: key code from the scanner.
- `valid` in 1: scanner strobe; `code` is meaningful only when this is high.
- `out_code` out 4: code at the FIFO head.
- `out_valid` out 1: FIFO is not empty.
- `out_ready` in 1: consumer accepts the head entry.
- `fifo_count` out $clog2(DEPTH)+1: current number of entries, 0..DEPTH.
- `overflow` out 1: sticky flag; set when an accepted press is dropped because the FIFO is full.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- **States:** IDLE, QUALIFY, HELD.
- **Internal registers:**
  - `cand` (4b): candidate code.
  - `match_cnt` (4b): count of matching strobes.
  - `gap_cnt` (8b): cycles since the last strobe.
- **IDLE:**
  - `valid`=1 → `cand`=`code`, `match_cnt`=1, `gap_cnt`=0, go to QUALIFY.
  - Otherwise stay in IDLE.
- **QUALIFY:**
  - `valid`=1 and `code`==`cand` → `match_cnt`++, `gap_cnt`=0. If the new `match_cnt`==MATCH_COUNT, raise the internal `push` and go to HELD.
  - `valid`=1 and `code`!=`cand` → `cand`=`code`, `match_cnt`=1, `gap_cnt`=0, stay in QUALIFY.
  - `valid`=0 → `gap_cnt`++. When `gap_cnt` reaches GAP_CYCLES-1 on this cycle, go to IDLE; `match_cnt` is discarded.
- **HELD:**
  - Any `valid`=1 → `gap_cnt`=0. A different code is ignored; there is no rollover and no repeat.
  - `valid`=0 → `gap_cnt`++. At GAP_CYCLES-1, go to IDLE.
  - A new press is accepted only after passing through IDLE.
- **FIFO push:**
  - A `push` is written when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
- **FIFO pop:** happens when `out_valid && out_ready`.
- **`overflow`:**
  - Set has priority over `ovf_clr` in the same cycle.
  - Cleared only by `ovf_clr` or `rst`.
- **Counts:**
  - `fifo_count` goes +1 on push only, −1 on pop only, and is unchanged on push+pop.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- **Reset values:**
  - state=IDLE; `cand`, `match_cnt`, `gap_cnt`=0.
  - FIFO empty: `out_valid`=0, `fifo_count`=0, `out_code`=0, `overflow`=0.
- **Reset mid-operation:**
  - A partial qualification and all buffered entries are lost.
  - A key still strobing after `rst` falls is qualified as a new press.

## Timing
- `push` is raised combinationally in the cycle of the MATCH_COUNT-th matching strobe.
- The entry is written at the end of that cycle, and `out_valid`/`out_code` reflect it on the next cycle. Latency from the qualifying strobe to `out_valid` is 1 cycle.
- `out_code` is the registered head entry and is stable while `out_valid`=1 and `out_ready`=0.
- After a pop, the next entry (if any) is presented in the following cycle. Sustained throughput is 1 pop per cycle.
- Release detection takes GAP_CYCLES cycles with no strobe, measured from the last strobe.
- GAP_CYCLES must exceed the scanner's worst-case spacing between strobes while a key is held, so the scan cycle (s_0→s_4) plus the s_5 hold period must fit inside it.

## Structure
- **Package `keypad_pkg`:**
  - `KEY_W`=4.
  - State enum `kev_state_t` {IDLE, QUALIFY, HELD}.
  - Shared with the scanner for the code width.
- **Sub-module `sync_fifo`:**
  - Parameterized width and depth; sync reset.
  - Signals: push/pop/full/empty/count, registered head output.
- The qualifier FSM stays in `keypad_event_buffer`.

## Test plan
- **Clean press:** `code`=0x5 with `valid` pulsed every 3 cycles ×6, then silence ≥64 cycles → exactly one entry 0x5. `out_valid` rises 1 cycle after the 4th strobe.
- **Bounce:** strobes 0x5, 0x9, 0x5, 0x5, 0x5, 0x5 → one entry 0x5, accepted on the 6th strobe. The 0x9 restarts the count.
- **Short press:** 3 strobes of 0xA, then 64 silent cycles → no entry, state back to IDLE. A following 4-strobe 0xA press is accepted.
- **Held key with a different code:** after 0x3 is accepted, strobes of 0xC with no gap → no new entry. After a 64-cycle gap, 4 strobes of 0xC → entry 0xC.
- **Overflow:** `out_ready`=0, nine separate presses 0x0..0x8 → `fifo_count`=8, `overflow`=1, and entries drain as 0x0..0x7. `ovf_clr` → `overflow`=0.
- **Full, push+pop in one cycle, then reset:** FIFO full with `out_ready`=1 in the same cycle as a push → count stays 8 and `overflow` stays 0. Then `rst` mid-QUALIFY → `out_valid`=0, `fifo_count`=0 on the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad path: key code width and the
// qualifier state encoding used by keypad_event_buffer.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        HELD
    } kev_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry, so the consumer sees a
// flop output that holds steady while it is stalled.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_en;
    logic             push_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = head_q;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_comb begin
        rd_ptr_d = rd_ptr_q + (pop_en  ? PTR_W'(1) : PTR_W'(0));
        wr_ptr_d = wr_ptr_q + (push_en ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The incoming word becomes the head when nothing older remains.
        head_d = head_q;
        if (push_en && (count_q == (pop_en ? CNT_W'(1) : CNT_W'(0)))) begin
            head_d = wdata;
        end else if (pop_en) begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/keypad_event_buffer.sv
// Qualifies scanner strobes into one event per keypress and queues the
// accepted codes for a valid/ready consumer.
module keypad_event_buffer
    import keypad_pkg::*;
#(
    parameter int MATCH_COUNT = 4,
    parameter int GAP_CYCLES  = 64,
    parameter int DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_W-1:0]         code,
    input  logic                     valid,
    output logic [KEY_W-1:0]         out_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    kev_state_t       state_q, state_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        match_cnt_d = match_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    cand_d      = code;
                    match_cnt_d = 4'd1;
                    gap_cnt_d   = 8'd0;
                    state_d     = QUALIFY;
                end
            end
            QUALIFY: begin
                if (valid && (code == cand_q)) begin
                    match_cnt_d = match_cnt_q + 4'd1;
                    gap_cnt_d   = 8'd0;
                    if (match_cnt_d == 4'(MATCH_COUNT)) begin
                        push    = 1'b1;
                        state_d = HELD;
                    end
                end else if (valid) begin
                    cand_d      = code;
                    match_cnt_d = 4'd1;
                    gap_cnt_d   = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                    if (gap_cnt_d == 8'(GAP_CYCLES - 1)) begin
                        state_d     = IDLE;
                        match_cnt_d = 4'd0;
                        gap_cnt_d   = 8'd0;
                    end
                end
            end
            HELD: begin
                // Any strobe, even with another code, just proves the key is still down.
                if (valid) begin
                    gap_cnt_d = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                    if (gap_cnt_d == 8'(GAP_CYCLES - 1)) begin
                        state_d     = IDLE;
                        match_cnt_d = 4'd0;
                        gap_cnt_d   = 8'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = out_valid && out_ready;

    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            match_cnt_q <= '0;
            gap_cnt_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            match_cnt_q <= match_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (cand_q),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (out_code)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_event_buffer.sv
// Directed bench for keypad_event_buffer: presses, bounce, release timing,
// overflow and reset, each checked against hand-computed values.
module tb_keypad_event_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code;
    logic       valid;
    logic [3:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    keypad_event_buffer #(
        .MATCH_COUNT (4),
        .GAP_CYCLES  (64),
        .DEPTH       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .valid      (valid),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [3:0] c);
        code  = c;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] c);
        for (int i = 0; i < 4; i++) strobe(c);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; code = '0; valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Clean press: strobe every 3 cycles
        for (int i = 0; i < 6; i++) begin
            strobe(4'h5);
            if (i == 2) chk("clean_before_4th", out_valid, 0);
            if (i == 3) begin
                chk("clean_valid_after_4th", out_valid, 1);
                chk("clean_code", out_code, 4'h5);
            end
            idle(2);
        end
        idle(64);
        chk("clean_one_entry", fifo_count, 1);
        pop_one();
        chk("clean_drained", out_valid, 0);

        // Bounce: 0x9 restarts qualification
        strobe(4'h5); strobe(4'h9); strobe(4'h5); strobe(4'h5); strobe(4'h5);
        chk("bounce_not_yet", fifo_count, 0);
        strobe(4'h5);
        chk("bounce_accepted", fifo_count, 1);
        chk("bounce_code", out_code, 4'h5);
        idle(70);
        pop_one();

        // Short press then a real one
        strobe(4'hA); strobe(4'hA); strobe(4'hA);
        idle(64);
        chk("short_no_entry", fifo_count, 0);
        strobe(4'hA); strobe(4'hA); strobe(4'hA);
        chk("short_restart_3", fifo_count, 0);
        strobe(4'hA);
        chk("short_then_full", fifo_count, 1);
        chk("short_code", out_code, 4'hA);
        idle(70);
        pop_one();

        // Held key, different code ignored until release
        press(4'h3);
        for (int i = 0; i < 8; i++) strobe(4'hC);
        chk("held_ignored", fifo_count, 1);
        idle(64);
        press(4'hC);
        chk("held_new_entry", fifo_count, 2);
        chk("held_head", out_code, 4'h3);
        pop_one();
        chk("held_second", out_code, 4'hC);
        pop_one();
        chk("held_drained", fifo_count, 0);
        idle(70);

        // Overflow
        for (int k = 0; k < 9; k++) begin
            press(4'(k));
            idle(64);
            if (k == 7) chk("ovf_count_at_8", fifo_count, 8);
            if (k == 7) chk("ovf_not_yet", overflow, 0);
        end
        chk("ovf_count_full", fifo_count, 8);
        chk("ovf_set", overflow, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain_%0d", k), out_code, 32'(k));
            pop_one();
        end
        chk("ovf_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full with push and pop in the same cycle
        for (int k = 0; k < 8; k++) begin
            press(4'(k));
            idle(64);
        end
        chk("pp_full", fifo_count, 8);
        strobe(4'h8); strobe(4'h8); strobe(4'h8);
        code = 4'h8; valid = 1'b1; out_ready = 1'b1;
        tick();
        valid = 1'b0; out_ready = 1'b0;
        chk("pp_count", fifo_count, 8);
        chk("pp_no_ovf", overflow, 0);
        chk("pp_head", out_code, 4'h1);
        idle(70);

        // Reset mid-qualify with key still strobing afterwards
        strobe(4'hE); strobe(4'hE);
        rst = 1'b1; code = 4'hE; valid = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", fifo_count, 0);
        strobe(4'hE); strobe(4'hE); strobe(4'hE);
        chk("rst_requal_3", fifo_count, 0);
        strobe(4'hE);
        chk("rst_requal_4", fifo_count, 1);
        chk("rst_requal_code", out_code, 4'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
